alu_operand_wb_stage: RTL and testbench

- Operand-fetch and writeback stage wrapped around the 16-bit combinational ALU (ports A, B, Cin, aluop[7:0], ImmLo[3:0], Result, Flags CLFZN).
- Accepts one instruction word per handshake and reads the 16x16 register file. Drives the ALU operands and operation code, then writes Result back to the destination register and updates the processor status register (PSR).
- Sits between the instruction fetch/decode front end and the ALU.

---
 rtl/alu_operand_wb_stage.sv | 83 ++++++++
 tb/tb_alu_operand_wb_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_operand_wb_stage.sv
// alu_operand_wb_stage: operand fetch, ALU drive and writeback around a 16-bit combinational ALU
module alu_operand_wb_stage #(
  parameter int WIDTH = 16,
  parameter int REGS  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [7:0]       alu_op,
  output logic [3:0]       alu_immlo,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [4:0]       alu_flags,
  output logic [4:0]       psr,
  output logic             wb_done,
  output logic             illegal,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t           state;
  logic [WIDTH-1:0] regs [REGS];
  logic [3:0]       rdest;
  logic [WIDTH-1:0] res_q;
  logic [4:0]       flg_q;
  logic [3:0]       op, code;
  logic [WIDTH-1:0] opb;
  logic             accept, legal, wr_en, psr_en;
  // Decode the incoming word into the normalized code and the B operand
  always_comb begin
    op     = instr[15:12];
    code   = op == 4'h0 ? instr[7:4] : op;
    opb    = op == 4'h0 ? regs[instr[3:0]] :
             (op == 4'h5 || op == 4'h9 || op == 4'hB || op == 4'hD) ? {{(WIDTH-8){instr[7]}}, instr[7:0]} :
             {{(WIDTH-8){1'b0}}, instr[7:0]};
    accept = in_valid && state == IDLE;
    legal  = alu_op[3:0] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    wr_en  = state == WB && legal && alu_op[3:0] != 4'hB;
    psr_en = state == WB && alu_op[3:0] inside {4'h5, 4'h9, 4'hB};
  end
  assign in_ready = state == IDLE;
  assign dbg_data = regs[dbg_addr];
  // Sequencer, operand latches, result capture and writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      psr       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_immlo <= '0;
      alu_cin   <= 1'b0;
      rdest     <= '0;
      res_q     <= '0;
      flg_q     <= '0;
      wb_done   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state   <= accept ? EXEC : state == EXEC ? WB : IDLE;
      wb_done <= state == EXEC;
      illegal <= state == EXEC && !legal;
      if (accept) begin
        alu_a     <= regs[instr[11:8]];
        alu_b     <= opb;
        alu_op    <= {4'b0000, code};
        alu_immlo <= instr[3:0];
        alu_cin   <= psr[4];
        rdest     <= instr[11:8];
      end
      if (state == EXEC) begin
        res_q <= alu_result;
        flg_q <= alu_flags;
      end
      if (wr_en) regs[rdest] <= res_q;
      if (psr_en) psr <= flg_q;
    end
  end
endmodule

// File: tb/tb_alu_operand_wb_stage.sv
// tb_alu_operand_wb_stage: directed vector bench with a reference ALU model
module tb_alu_operand_wb_stage;
  logic        clk = 0, reset = 0, in_valid = 0;
  logic        in_ready, alu_cin, wb_done, illegal;
  logic [15:0] instr = '0, alu_a, alu_b, alu_result, dbg_data;
  logic [7:0]  alu_op;
  logic [3:0]  alu_immlo, dbg_addr = '0;
  logic [4:0]  alu_flags, psr;
  int n = 0, nfail = 0, pulses;

  alu_operand_wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op), .alu_immlo(alu_immlo),
    .alu_result(alu_result), .alu_flags(alu_flags), .psr(psr), .wb_done(wb_done),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU: flags {C carry/borrow, L signed less, F overflow, Z, N}
  logic [16:0] sum, dif;
  logic [15:0] r;
  logic        c, f;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    dif = {1'b0, alu_a} - {1'b0, alu_b};
    c = 1'b0;
    f = 1'b0;
    case (alu_op[3:0])
      4'h1: r = alu_a & alu_b;
      4'h2: r = alu_a | alu_b;
      4'h3: r = alu_a ^ alu_b;
      4'h5: begin r = sum[15:0]; c = sum[16]; f = (alu_a[15] == alu_b[15]) && (r[15] != alu_a[15]); end
      4'h9, 4'hB: begin r = dif[15:0]; c = dif[16]; f = (alu_a[15] != alu_b[15]) && (r[15] != alu_a[15]); end
      4'hD: r = alu_b;
      default: r = 16'hDEAD;
    endcase
    alu_result = r;
    alu_flags  = {c, $signed(alu_a) < $signed(alu_b), f, r == 16'h0, r[15]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a, b;
    logic [7:0]  op;
    logic        cin;
    logic [15:0] rd_val;
    logic [4:0]  psr;
    logic        ill;
  } vec_t;

  vec_t v[12];
  logic [15:0] mr [16];

  initial begin
    v[0]  = '{16'hD108, 16'h0000, 16'h0008, 8'h0D, 1'b0, 16'h0008, 5'b00000, 1'b0};
    v[1]  = '{16'hD209, 16'h0000, 16'h0009, 8'h0D, 1'b0, 16'h0009, 5'b00000, 1'b0};
    v[2]  = '{16'h0152, 16'h0008, 16'h0009, 8'h05, 1'b0, 16'h0011, 5'b01000, 1'b0};
    v[3]  = '{16'h01B1, 16'h0011, 16'h0011, 8'h0B, 1'b0, 16'h0011, 5'b00010, 1'b0};
    v[4]  = '{16'h53FF, 16'h0000, 16'hFFFF, 8'h05, 1'b0, 16'hFFFF, 5'b00001, 1'b0};
    v[5]  = '{16'h53FF, 16'hFFFF, 16'hFFFF, 8'h05, 1'b0, 16'hFFFE, 5'b10001, 1'b0};
    v[6]  = '{16'hD4FF, 16'h0000, 16'hFFFF, 8'h0D, 1'b1, 16'hFFFF, 5'b10001, 1'b0};
    v[7]  = '{16'h14F0, 16'hFFFF, 16'h00F0, 8'h01, 1'b1, 16'h00F0, 5'b10001, 1'b0};
    v[8]  = '{16'h0070, 16'h0000, 16'h0000, 8'h07, 1'b1, 16'h0000, 5'b10001, 1'b1};
    v[9]  = '{16'h9101, 16'h0011, 16'h0001, 8'h09, 1'b1, 16'h0010, 5'b00000, 1'b0};
    v[10] = '{16'h2580, 16'h0000, 16'h0080, 8'h02, 1'b0, 16'h0080, 5'b00000, 1'b0};
    v[11] = '{16'h0534, 16'h0080, 16'h00F0, 8'h03, 1'b0, 16'h0070, 5'b00000, 1'b0};
    for (int i = 0; i < 16; i++) mr[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset psr", psr, 0);
    chk("reset alu_a", alu_a, 0);
    chk("reset alu_b", alu_b, 0);
    chk("reset alu_op", alu_op, 0);
    chk("reset wb_done", wb_done, 0);
    chk("reset illegal", illegal, 0);
    @(negedge clk) reset = 1;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] rd;
      rd = v[i].instr[11:8];
      @(negedge clk);
      in_valid = 1;
      instr = v[i].instr;
      dbg_addr = rd;
      @(posedge clk) #1;
      in_valid = 0;
      chk($sformatf("v%0d exec in_ready", i), in_ready, 0);
      chk($sformatf("v%0d alu_a", i), alu_a, v[i].a);
      chk($sformatf("v%0d alu_b", i), alu_b, v[i].b);
      chk($sformatf("v%0d alu_op", i), alu_op, v[i].op);
      chk($sformatf("v%0d alu_immlo", i), alu_immlo, v[i].instr[3:0]);
      chk($sformatf("v%0d alu_cin", i), alu_cin, v[i].cin);
      chk($sformatf("v%0d exec wb_done", i), wb_done, 0);
      @(posedge clk) #1;
      chk($sformatf("v%0d wb in_ready", i), in_ready, 0);
      chk($sformatf("v%0d wb_done", i), wb_done, 1);
      chk($sformatf("v%0d illegal", i), illegal, v[i].ill);
      chk($sformatf("v%0d wb old reg", i), dbg_data, mr[rd]);
      @(posedge clk) #1;
      mr[rd] = v[i].rd_val;
      chk($sformatf("v%0d in_ready", i), in_ready, 1);
      chk($sformatf("v%0d wb_done low", i), wb_done, 0);
      chk($sformatf("v%0d illegal low", i), illegal, 0);
      chk($sformatf("v%0d reg", i), dbg_data, v[i].rd_val);
      chk($sformatf("v%0d psr", i), psr, v[i].psr);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) dbg_addr = 4'(i);
      #1 chk($sformatf("final R%0d", i), dbg_data, mr[i]);
    end
    // in_valid held high across one instruction must be accepted only once
    pulses = 0;
    @(negedge clk);
    in_valid = 1;
    instr = 16'hD605;
    dbg_addr = 4'h6;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk) #1;
      if (k == 1) in_valid = 0;
      if (wb_done) pulses++;
      if (k < 2) chk($sformatf("held in_ready k%0d", k), in_ready, 0);
    end
    chk("held single wb_done", pulses, 1);
    chk("held R6", dbg_data, 16'h0005);
    // Reset during EXEC abandons the instruction
    @(negedge clk);
    in_valid = 1;
    instr = 16'h0756;
    dbg_addr = 4'h7;
    @(posedge clk) #1;
    in_valid = 0;
    chk("rst exec in_ready", in_ready, 0);
    #2 reset = 0;
    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst psr", psr, 0);
    chk("rst R7", dbg_data, 0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk) #1;
      if (wb_done) pulses++;
    end
    @(negedge clk) reset = 1;
    repeat (3) begin
      @(posedge clk) #1;
      if (wb_done) pulses++;
    end
    chk("rst no wb_done", pulses, 0);
    chk("rst R7 after", dbg_data, 0);
    chk("rst psr after", psr, 0);
    chk("rst idle", in_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, nfail);
    $finish;
  end
endmodule
